// File: rtl/replica_pkg.sv
// Shared types for the replica engine: chain word type and readout controller types.
package replica_pkg;

    localparam int unsigned TOTAL_W = 32;
    typedef logic [TOTAL_W-1:0] total_data_t;

    localparam int unsigned RD_FIFO_DEPTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_RUN,
        SHIFT,
        DRAIN
    } readout_state_t;

endpackage

// File: rtl/rd_fifo.sv
// First-word-fall-through buffer with synchronous flush; push accepted when full if a pop frees the slot.
module rd_fifo #(
    parameter int unsigned width = 8,
    parameter int unsigned depth = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [width-1:0] din,
    input  logic             pop,
    output logic [width-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(depth);

    logic [width-1:0] mem [depth];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        empty   = (wr_ptr == rd_ptr);
        full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        dout    = mem[rd_ptr[AW-1:0]];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/replica_readout_ctrl.sv
// Non-destructive snapshot readout of the distance chains: rotates the chains by a full
// period, streaming each tail word through an output buffer.
module replica_readout_ctrl
    import replica_pkg::*;
#(
    parameter int unsigned replica_num = 32,
    parameter int unsigned fifo_depth  = RD_FIFO_DEPTH_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic        running,
    input  total_data_t distance_rdata,
    output logic        distance_shift,
    output total_data_t distance_wdata,
    output logic        m_valid,
    input  logic        m_ready,
    output total_data_t m_data,
    output logic        m_last,
    output logic        busy,
    output logic        done
);

    localparam int unsigned WORDS = 2 * replica_num;
    localparam int unsigned CW    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(WORDS - 1);

    readout_state_t state, state_next;
    logic [CW-1:0]  cnt, cnt_next;

    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;
    logic             fifo_flush;
    logic [TOTAL_W:0] fifo_din;
    logic [TOTAL_W:0] fifo_dout;
    logic             shift_ok;

    rd_fifo #(
        .width(TOTAL_W + 1),
        .depth(fifo_depth)
    ) u_fifo (
        .clk  (clk),
        .reset(reset),
        .flush(fifo_flush),
        .push (shift_ok),
        .din  (fifo_din),
        .pop  (fifo_pop),
        .dout (fifo_dout),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        done       = 1'b0;
        fifo_pop   = !fifo_empty && m_ready;
        fifo_flush = abort && (state != IDLE);
        // a pop in the same cycle frees the slot the shifted word lands in
        shift_ok   = (state == SHIFT) && !running && !abort && (!fifo_full || fifo_pop);
        fifo_din   = {cnt == LAST_IDX, distance_rdata};

        case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_next = WAIT_RUN;
                    cnt_next   = '0;
                end
            end
            WAIT_RUN: begin
                if (!running) state_next = SHIFT;
            end
            SHIFT: begin
                if (shift_ok) begin
                    if (cnt == LAST_IDX) state_next = DRAIN;
                    else                 cnt_next   = cnt + CW'(1);
                end
            end
            DRAIN: begin
                if (fifo_pop && fifo_dout[TOTAL_W]) begin
                    state_next = IDLE;
                    done       = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        if (fifo_flush) begin
            state_next = IDLE;
            cnt_next   = '0;
            done       = 1'b0;
        end
    end

    always_comb begin
        distance_shift = shift_ok;
        distance_wdata = shift_ok ? distance_rdata : '0;
        m_valid        = !fifo_empty;
        m_data         = fifo_dout[TOTAL_W-1:0];
        m_last         = !fifo_empty && fifo_dout[TOTAL_W];
        busy           = (state != IDLE);
    end

endmodule

// File: tb/tb_replica_readout_ctrl.sv
// Randomised scoreboard bench for replica_readout_ctrl with a rotating-chain environment model.
module tb_replica_readout_ctrl;
    import replica_pkg::*;

    localparam int unsigned N = 4;
    localparam int unsigned W = 2 * N;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        running = 1'b0;
    logic        m_ready = 1'b1;
    total_data_t distance_rdata;
    total_data_t distance_wdata;
    total_data_t m_data;
    logic        distance_shift;
    logic        m_valid;
    logic        m_last;
    logic        busy;
    logic        done;

    replica_readout_ctrl #(
        .replica_num(N),
        .fifo_depth (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .abort         (abort),
        .running       (running),
        .distance_rdata(distance_rdata),
        .distance_shift(distance_shift),
        .distance_wdata(distance_wdata),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_data        (m_data),
        .m_last        (m_last),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    // The chain: tail word out, fed-back word in at the head of the rotation.
    total_data_t chain [W];
    total_data_t load_val [W];
    logic        load = 1'b0;

    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < W; i++) chain[i] <= load_val[i];
        end else if (distance_shift) begin
            for (int i = 0; i < W - 1; i++) chain[i] <= chain[i+1];
            chain[W-1] <= distance_wdata;
        end
    end
    assign distance_rdata = chain[0];

    int           checks = 0;
    int           passes = 0;
    logic [32:0]  exp_q [$];
    total_data_t  rx_q [$];
    int           shifts = 0;
    int           dones = 0;
    int           rd_idx = 0;
    logic         prev_stall = 1'b0;
    logic         prev_abort = 1'b0;
    total_data_t  prev_data = '0;
    total_data_t  snap [W];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Monitor: pops the scoreboard on every accepted word; pushes on every chain shift.
    always @(negedge clk) begin
        logic [32:0] e;
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && !prev_abort) begin
                check("hold_valid", 64'(m_valid), 64'(1));
                check("hold_data", 64'(m_data), 64'(prev_data));
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 64'(1), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("data", 64'(m_data), 64'(e[31:0]));
                    check("last", 64'(m_last), 64'(e[32]));
                    check("done", 64'(done), 64'(e[32] && !abort));
                end
                rx_q.push_back(m_data);
            end else if (done) begin
                check("spurious_done", 64'(done), 64'(0));
            end
            if (done) dones++;
            if (distance_shift) begin
                check("wdata_echo", 64'(distance_wdata), 64'(distance_rdata));
                rd_idx++;
                shifts++;
                exp_q.push_back({rd_idx == W, distance_rdata});
            end else begin
                check("wdata_idle", 64'(distance_wdata), 64'(0));
            end
            if (abort) exp_q.delete();
            prev_stall = m_valid && !m_ready;
            prev_abort = abort;
            prev_data  = m_data;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_load;
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic load_seq(input int base);
        for (int i = 0; i < W; i++) load_val[i] = total_data_t'(base + i);
        pulse_load();
    endtask

    task automatic load_rand;
        for (int i = 0; i < W; i++) load_val[i] = $urandom;
        pulse_load();
    endtask

    task automatic do_start;
        rd_idx = 0;
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    task automatic clear_stats;
        rx_q.delete();
        shifts = 0;
        dones  = 0;
    endtask

    task automatic wait_idle(input int budget, input bit rnd);
        int n = 0;
        while (busy && n < budget) begin
            if (rnd) begin
                m_ready = 1'($urandom_range(0, 1));
                running = ($urandom_range(0, 7) == 0);
            end
            tick();
            n++;
        end
        running = 1'b0;
        m_ready = 1'b1;
        if (busy) check("idle_timeout", 64'(busy), 64'(0));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_shift"}, 64'(distance_shift), 64'(0));
        check({tag, "_wdata"}, 64'(distance_wdata), 64'(0));
        check({tag, "_valid"}, 64'(m_valid), 64'(0));
        check({tag, "_last"},  64'(m_last), 64'(0));
        check({tag, "_busy"},  64'(busy), 64'(0));
        check({tag, "_done"},  64'(done), 64'(0));
    endtask

    task automatic check_words(input string tag);
        check({tag, "_shifts"}, 64'(shifts), 64'(W));
        check({tag, "_dones"}, 64'(dones), 64'(1));
        check({tag, "_count"}, 64'(rx_q.size()), 64'(W));
        for (int i = 0; i < W; i++) begin
            if (i < rx_q.size()) check({tag, "_word"}, 64'(rx_q[i]), 64'(snap[i]));
        end
        for (int i = 0; i < W; i++) check({tag, "_chain_kept"}, 64'(chain[i]), 64'(snap[i]));
        check({tag, "_busy_end"}, 64'(busy), 64'(0));
    endtask

    task automatic readout(input string tag, input bit rnd);
        for (int i = 0; i < W; i++) snap[i] = chain[i];
        clear_stats();
        do_start();
        wait_idle(2000, rnd);
        check_words(tag);
    endtask

    task automatic set_snap_seq(input int base);
        for (int i = 0; i < W; i++) snap[i] = total_data_t'(base + i);
    endtask

    initial begin
        int n;
        load_seq(1);
        tick();
        check_reset_outputs("reset");
        reset = 1'b0;
        tick();

        // Plain readout, then a second one proving the rotation is non-destructive.
        readout("basic", 1'b0);
        set_snap_seq(1);
        for (int i = 0; i < W; i++) if (i < rx_q.size()) check("basic_abs", 64'(rx_q[i]), 64'(snap[i]));
        readout("again", 1'b0);
        for (int i = 0; i < W; i++) if (i < rx_q.size()) check("again_abs", 64'(rx_q[i]), 64'(snap[i]));

        // Backpressure: only the buffer depth may be shifted while m_ready is low.
        clear_stats();
        m_ready = 1'b0;
        do_start();
        repeat (20) tick();
        check("stall_shifts", 64'(shifts), 64'(4));
        check("stall_noshift", 64'(distance_shift), 64'(0));
        check("stall_valid", 64'(m_valid), 64'(1));
        m_ready = 1'b1;
        wait_idle(200, 1'b0);
        set_snap_seq(1);
        check_words("stall");

        // Engine busy at start: no shift until running falls, first shift the cycle after.
        clear_stats();
        running = 1'b1;
        do_start();
        repeat (9) tick();
        check("run_noshift", 64'(shifts), 64'(0));
        check("run_busy", 64'(busy), 64'(1));
        running = 1'b0;
        @(negedge clk);
        check("run_fall_cycle", 64'(distance_shift), 64'(0));
        @(posedge clk);
        #1;
        @(negedge clk);
        check("run_first_shift", 64'(distance_shift), 64'(1));
        wait_idle(200, 1'b0);
        set_snap_seq(1);
        check_words("run");

        // Abort after a few words, then a fresh readout of the (rotated) chain.
        clear_stats();
        do_start();
        n = 0;
        while (rx_q.size() < 3 && n < 100) begin
            tick();
            n++;
        end
        check("abort_reached3", 64'(rx_q.size() >= 3), 64'(1));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_valid", 64'(m_valid), 64'(0));
        check("abort_nodone", 64'(dones), 64'(0));
        readout("post_abort", 1'b0);

        // Randomised backpressure and engine activity over random chain contents.
        for (int r = 0; r < 6; r++) begin
            load_rand();
            readout("rand", 1'b1);
        end

        // Asynchronous reset between edges while shifting.
        load_seq(100);
        clear_stats();
        do_start();
        repeat (3) tick();
        check("pre_reset_shift", 64'(distance_shift), 64'(1));
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("async");
        exp_q.delete();
        tick();
        reset = 1'b0;
        tick();
        readout("post_reset", 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running, required finished");
        $fatal(1, "timeout");
    end

endmodule
